// File: rtl/cardinal_pkg.sv
// Shared types and default widths for the cardinal load/store unit.
package cardinal_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } lsu_state_e;

    localparam int unsigned DefDataW   = 64;
    localparam int unsigned DefAddrW   = 32;
    localparam int unsigned DefTagW    = 5;
    localparam int unsigned DefDepth   = 4;
    localparam int unsigned DefTimeout = 255;

endpackage

// File: rtl/cardinal_fifo.sv
// In-order request queue: power-of-two ring buffer with an occupancy counter.
module cardinal_fifo
    import cardinal_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW-1:0]  r_wr_ptr;
    logic [LvlW-1:0]  r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == LvlW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/cardinal_lsu.sv
// Load/store unit: queues execute-stage requests and issues them to memory one at a time,
// with a per-access timeout and a one-cycle load writeback.
module cardinal_lsu
    import cardinal_pkg::*;
#(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned TAG_W   = DefTagW,
    parameter int unsigned DEPTH   = DefDepth,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wr,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [TAG_W-1:0]       req_rd,
    output logic                   mem_en,
    output logic                   mem_wr_en,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   wb_valid,
    output logic [TAG_W-1:0]       wb_rd,
    output logic [DATA_W-1:0]      wb_data,
    output logic                   wb_err,
    output logic                   err,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned EntW = 1 + ADDR_W + DATA_W + TAG_W;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam int unsigned LvlW = $clog2(DEPTH) + 1;

    lsu_state_e        r_state;
    lsu_state_e        w_state_d;
    logic [CntW-1:0]   r_wait;
    logic              r_wb_valid;
    logic [TAG_W-1:0]  r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_wb_err;
    logic              r_err;

    logic [EntW-1:0]   w_push_ent;
    logic [EntW-1:0]   w_head;
    logic              w_head_wr;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_wdata;
    logic [TAG_W-1:0]  w_head_rd;
    logic              w_full;
    logic              w_empty;
    logic [LvlW-1:0]   w_level;
    logic              w_push;
    logic              w_busy;
    logic              w_timeout;
    logic              w_done;
    logic              w_queue_left;

    assign w_push_ent = {req_wr, req_addr, req_wdata, req_rd};
    assign {w_head_wr, w_head_addr, w_head_wdata, w_head_rd} = w_head;

    cardinal_fifo #(
        .WIDTH (EntW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_wdata (w_push_ent),
        .i_pop   (w_done),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign req_ready = !w_full;
    assign level     = w_level;
    assign w_push    = req_valid && !w_full;
    assign w_busy    = (r_state == StBusy);
    // The access is abandoned at the end of its TIMEOUT-th unacknowledged cycle.
    assign w_timeout = w_busy && !mem_ack && (r_wait == CntW'(TIMEOUT - 1));
    assign w_done    = w_busy && (mem_ack || w_timeout);
    // Entries remaining after this cycle's pop and any concurrent push.
    assign w_queue_left = (w_level > LvlW'(1)) || w_push;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_state_d = StBusy;
                end
            end
            StBusy: begin
                if (w_done && !w_queue_left) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_busy) begin
            mem_en    = 1'b1;
            mem_wr_en = w_head_wr;
            mem_addr  = w_head_addr;
            mem_wdata = w_head_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait     <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_err   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wb_valid <= w_done && !w_head_wr;
            if (w_done || !w_busy) begin
                r_wait <= '0;
            end else begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_done && !w_head_wr) begin
                r_wb_rd   <= w_head_rd;
                r_wb_err  <= w_timeout;
                r_wb_data <= w_timeout ? '0 : mem_rdata;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign wb_err   = r_wb_err;
    assign err      = r_err;

endmodule

// File: tb/tb_cardinal_lsu.sv
// Self-checking bench for cardinal_lsu: directed table, corner sequences and random traffic
// compared against a queue-based reference model.
module tb_cardinal_lsu;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int TW = 5;
    localparam int DP = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [TW-1:0] req_rd;
    logic          mem_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          wb_valid;
    logic [TW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          wb_err;
    logic          err;
    logic [2:0]    level;

    cardinal_lsu #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TAG_W   (TW),
        .DEPTH   (DP),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rd    (req_rd),
        .mem_en    (mem_en),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_err    (wb_err),
        .err       (err),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [TW-1:0] rd;
    } req_t;

    typedef struct {
        logic          valid;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [TW-1:0] rd;
        logic          ack;
        logic [DW-1:0] rdata;
        logic [2:0]    e_level;
        logic          e_ready;
        logic          e_mem_en;
        logic          e_wb_valid;
        logic [DW-1:0] e_wb_data;
    } vec_t;

    // Reference model: queue of accepted requests, head is the access in flight.
    req_t          q[$];
    bit            m_busy;
    int            m_wait;
    bit            m_wb_pend;
    logic [TW-1:0] m_wb_rd;
    logic [DW-1:0] m_wb_data;
    bit            m_wb_err;
    bit            m_err;
    bit            m_accepted;
    int            wb_seen;
    int            checks;
    int            errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("level", 64'(level), 64'(q.size()));
        chk("req_ready", 64'(req_ready), 64'(q.size() < DP));
        chk("mem_en", 64'(mem_en), 64'(m_busy));
        if (m_busy && q.size() > 0) begin
            chk("mem_wr_en", 64'(mem_wr_en), 64'(q[0].wr));
            chk("mem_addr", 64'(mem_addr), 64'(q[0].addr));
            chk("mem_wdata", mem_wdata, q[0].wdata);
        end else begin
            chk("mem_wr_en_idle", 64'(mem_wr_en), 64'(0));
        end
        chk("wb_valid", 64'(wb_valid), 64'(m_wb_pend));
        if (m_wb_pend) begin
            chk("wb_rd", 64'(wb_rd), 64'(m_wb_rd));
            chk("wb_data", wb_data, m_wb_data);
            chk("wb_err", 64'(wb_err), 64'(m_wb_err));
        end
        chk("err", 64'(err), 64'(m_err));
        if (wb_valid === 1'b1) wb_seen++;
    endtask

    task automatic update_model();
        bit   acc;
        bit   done;
        bit   tmo;
        bit   nb;
        req_t r;
        if (!reset) begin
            q.delete();
            m_busy     = 0;
            m_wait     = 0;
            m_wb_pend  = 0;
            m_err      = 0;
            m_accepted = 0;
            return;
        end
        acc       = req_valid && (q.size() < DP);
        done      = 0;
        tmo       = 0;
        m_wb_pend = 0;
        if (m_busy) begin
            if (mem_ack) done = 1;
            else if (m_wait + 1 == TO) begin
                done = 1;
                tmo  = 1;
            end
            if (done && !q[0].wr) begin
                m_wb_pend = 1;
                m_wb_rd   = q[0].rd;
                m_wb_err  = tmo;
                m_wb_data = tmo ? '0 : mem_rdata;
            end
            if (tmo) m_err = 1;
        end
        m_wait = (m_busy && !done) ? m_wait + 1 : 0;
        if (!m_busy) nb = (q.size() > 0);
        else nb = !done || (q.size() - 1 + int'(acc) > 0);
        if (done) void'(q.pop_front());
        if (acc) begin
            r.wr    = req_wr;
            r.addr  = req_addr;
            r.wdata = req_wdata;
            r.rd    = req_rd;
            q.push_back(r);
        end
        m_busy     = nb;
        m_accepted = acc;
    endtask

    task automatic at_neg();
        @(negedge clk);
        check_model();
        update_model();
    endtask

    task automatic edge_done();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        at_neg();
        edge_done();
    endtask

    task automatic drive(input logic v, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [TW-1:0] rd,
                         input logic ack, input logic [DW-1:0] rdata);
        req_valid = v;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        req_rd    = rd;
        mem_ack   = ack;
        mem_rdata = rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int   k;
        int   cyc;
        int   loads;
        int   en_cnt;
        bit   got;

        checks = 0;
        errors = 0;
        wb_seen = 0;
        reset = 1'b0;
        drive(0, 0, '0, '0, '0, 0, '0);
        repeat (2) @(posedge clk);
        #1;
        update_model();

        // Reset state
        at_neg();
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", mem_wdata, 64'(0));
        chk("rst_wb_rd", 64'(wb_rd), 64'(0));
        chk("rst_wb_data", wb_data, 64'(0));
        chk("rst_wb_err", 64'(wb_err), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(1));
        edge_done();
        reset = 1'b1;

        // Single load, ack two cycles after mem_en rises; stray ack in idle
        tbl[0] = '{1, 0, 32'h10, 64'h0, 5'd3, 0, 64'h0, 3'd0, 1, 0, 0, 64'h0};
        tbl[1] = '{0, 0, 32'h0, 64'h0, 5'd0, 0, 64'h0, 3'd1, 1, 0, 0, 64'h0};
        tbl[2] = '{0, 0, 32'h0, 64'h0, 5'd0, 0, 64'h0, 3'd1, 1, 1, 0, 64'h0};
        tbl[3] = '{0, 0, 32'h0, 64'h0, 5'd0, 0, 64'h0, 3'd1, 1, 1, 0, 64'h0};
        tbl[4] = '{0, 0, 32'h0, 64'h0, 5'd0, 1, 64'hDEADBEEF, 3'd1, 1, 1, 0, 64'h0};
        tbl[5] = '{0, 0, 32'h0, 64'h0, 5'd0, 1, 64'h0, 3'd0, 1, 0, 1, 64'hDEADBEEF};
        tbl[6] = '{0, 0, 32'h0, 64'h0, 5'd0, 0, 64'h0, 3'd0, 1, 0, 0, 64'h0};
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].valid, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rd,
                  tbl[i].ack, tbl[i].rdata);
            at_neg();
            chk("tbl_level", 64'(level), 64'(tbl[i].e_level));
            chk("tbl_ready", 64'(req_ready), 64'(tbl[i].e_ready));
            chk("tbl_mem_en", 64'(mem_en), 64'(tbl[i].e_mem_en));
            chk("tbl_wb_valid", 64'(wb_valid), 64'(tbl[i].e_wb_valid));
            if (tbl[i].e_wb_valid) begin
                chk("tbl_wb_data", wb_data, tbl[i].e_wb_data);
                chk("tbl_wb_rd", 64'(wb_rd), 64'(3));
                chk("tbl_wb_err", 64'(wb_err), 64'(0));
            end
            edge_done();
        end

        // Five back-to-back stores with ack low until the queue fills
        k = 0;
        cyc = 0;
        while (k < 5 && cyc < 40) begin
            drive(1, 1, 32'h100 + 32'(k * 8), 64'hA000 + 64'(k), '0, cyc >= 5, '0);
            at_neg();
            if (cyc == 4) begin
                chk("full_level", 64'(level), 64'(4));
                chk("full_ready", 64'(req_ready), 64'(0));
            end
            edge_done();
            if (m_accepted) k++;
            cyc++;
        end
        chk("store_accepts", 64'(k), 64'(5));
        drive(0, 0, '0, '0, '0, 1, '0);
        for (int i = 0; i < 20 && (q.size() != 0 || m_busy); i++) cycle();
        chk("store_drain", 64'(level), 64'(0));
        mem_ack = 0;
        cycle();

        // Ack held high, one push per cycle across several pointer wraps
        wb_seen = 0;
        loads = 0;
        for (int c = 0; c < 16; c++) begin
            drive(1, 1'($urandom), $urandom, {$urandom, $urandom}, 5'($urandom), 1,
                  {$urandom, $urandom});
            if (!req_wr) loads++;
            at_neg();
            if (c >= 2) chk("stream_level", 64'(level), 64'(2));
            edge_done();
        end
        req_valid = 0;
        for (int i = 0; i < 10; i++) cycle();
        chk("stream_wb_count", 64'(wb_seen), 64'(loads));
        mem_ack = 0;

        // Load with no ack times out after TO cycles
        drive(1, 0, 32'h40, '0, 5'd7, 0, 64'h1234);
        en_cnt = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            at_neg();
            if (mem_en) en_cnt++;
            if (wb_valid) begin
                got = 1;
                chk("tmo_wb_err", 64'(wb_err), 64'(1));
                chk("tmo_wb_data", wb_data, 64'(0));
                chk("tmo_wb_rd", 64'(wb_rd), 64'(7));
            end
            edge_done();
            req_valid = 0;
        end
        chk("tmo_seen", 64'(got), 64'(1));
        chk("tmo_cycles", 64'(en_cnt), 64'(TO));
        repeat (3) cycle();
        chk("err_sticky", 64'(err), 64'(1));

        // Reset while busy with three queued loads, then a late ack
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 32'h200 + 32'(c), '0, 5'(c + 1), 0, '0);
            cycle();
        end
        req_valid = 0;
        reset = 0;
        at_neg();
        chk("pre_rst_level", 64'(level), 64'(3));
        chk("pre_rst_busy", 64'(mem_en), 64'(1));
        edge_done();
        reset = 1;
        mem_ack = 1;
        mem_rdata = 64'hFFFF;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("post_rst_wb", 64'(wb_valid), 64'(0));
            chk("post_rst_en", 64'(mem_en), 64'(0));
            chk("post_rst_level", 64'(level), 64'(0));
            chk("post_rst_err", 64'(err), 64'(0));
            edge_done();
        end

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 60, 1'($urandom), $urandom, {$urandom, $urandom},
                  5'($urandom), $urandom_range(0, 99) < 35, {$urandom, $urandom});
            reset = ($urandom_range(0, 199) != 0);
            cycle();
        end
        reset = 1;
        drive(0, 0, '0, '0, '0, 1, '0);
        repeat (8) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cardinal_lsu.md
CARDINAL_LSU -- requirements
Module: cardinal_lsu

Interface
REQ-001 The block SHALL have parameters: DATA_W default 64, data word width; ADDR_W default 32, memory address width; TAG_W default 5, destination-register tag width; DEPTH default 4, request queue entries (power of two, >=2); TIMEOUT default 255, maximum cycles to wait for mem_ack (>=1).
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be, one per line:
clk  in  1  system clock, rising edge
reset  in  1  synchronous active-low reset
req_valid  in  1  request offered by execute stage
req_ready  out  1  queue can accept (pipeline stall = !req_ready)
req_wr  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data
req_rd  in  TAG_W  load destination register
mem_en  out  1  memory access strobe
mem_wr_en  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completes current access
mem_rdata  in  DATA_W  load data, valid with mem_ack
wb_valid  out  1  one-cycle load writeback pulse
wb_rd  out  TAG_W  writeback register
wb_data  out  DATA_W  writeback data
wb_err  out  1  qualifies wb_valid: load timed out
err  out  1  sticky timeout flag
level  out  clog2(DEPTH)+1  queue occupancy

Function
REQ-004 The request SHALL be accepted on a rising edge with req_valid && req_ready; req_ready SHALL equal (level < DEPTH), computed from registered state only (no same-cycle pop bypass).
REQ-005 Accepted requests SHALL be issued to memory strictly in order, one outstanding access at a time.
REQ-006 The FSM SHALL have states IDLE and BUSY; IDLE->BUSY when the queue is non-empty; BUSY->BUSY on completion if the queue is still non-empty after the pop and any concurrent push; BUSY->IDLE on completion otherwise.
REQ-007 In BUSY, mem_en SHALL be 1 and mem_wr_en, mem_addr, mem_wdata SHALL reflect the queue head and stay stable until completion; in IDLE mem_en and mem_wr_en SHALL be 0.
REQ-008 Latency: a request accepted at edge t into an empty idle block SHALL see mem_en high in the cycle after edge t+1 at the earliest, i.e. the access is registered out one cycle after acceptance.
REQ-009 Completion SHALL be mem_ack sampled high in BUSY, or the wait counter reaching TIMEOUT; the head entry SHALL be popped on completion.
REQ-010 The wait counter SHALL clear on entry to each access and increment each BUSY cycle without mem_ack.
REQ-011 A load completing by mem_ack SHALL produce wb_valid=1, wb_err=0, wb_rd=tag, wb_data=registered mem_rdata in the following cycle only.
REQ-012 A load completing by timeout SHALL produce wb_valid=1, wb_err=1, wb_data=0 next cycle; any timeout (load or store) SHALL set err until reset.
REQ-013 Stores SHALL never assert wb_valid.
REQ-014 mem_ack in IDLE, or a second ack beyond the one completing the current access, SHALL be ignored.
REQ-015 Simultaneous push and pop SHALL leave level unchanged; push when full SHALL not occur (req_ready=0); pointers SHALL wrap modulo DEPTH.

Reset
REQ-016 While reset=0 at an edge: state IDLE, queue empty, level 0, req_ready 1, mem_en 0, mem_wr_en 0, mem_addr 0, mem_wdata 0, wb_valid 0, wb_rd 0, wb_data 0, wb_err 0, err 0, wait counter 0.
REQ-017 Reset mid-access SHALL discard all queued and outstanding requests; no wb_valid SHALL result from them.

Structure
REQ-018 The FSM state encoding and default widths SHALL live in shared package cardinal_pkg.
REQ-019 The queue SHALL be a sub-module cardinal_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, level).

Verification
REQ-020 Load addr 0x10, rd 3; memory acks 2 cycles after mem_en with rdata 0xDEADBEEF -> one wb_valid, wb_rd=3, wb_data=0xDEADBEEF, wb_err=0.
REQ-021 Five back-to-back stores with ack held low -> req_ready=0 after fourth accept, level=4; release ack -> stores issue in order with correct addr and data.
REQ-022 Ack held high continuously while pushing one request per cycle -> level stable, in-order issue, no lost or duplicated entries across pointer wrap.
REQ-023 Load with no ack, TIMEOUT=8 -> completion after 8 wait cycles, wb_valid=1, wb_err=1, wb_data=0, err sticky.
REQ-024 Reset=0 asserted while BUSY with 3 queued entries, then ack arrives -> no wb_valid, mem_en=0, level=0.
